// File: rtl/binary_to_bcd_serial_if.sv
// Handshake and result bundle between a binary producer and the serial BCD converter.
interface binary_to_bcd_serial_if #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3
);
    logic                  start;
    logic [WIDTH-1:0]      binary;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic                  overflow;

    modport master (
        output start,
        output binary,
        input  busy,
        input  done,
        input  bcd,
        input  overflow
    );

    modport slave (
        input  start,
        input  binary,
        output busy,
        output done,
        output bcd,
        output overflow
    );
endinterface

// File: rtl/binary_to_bcd_serial.sv
// Serial double-dabble binary-to-BCD converter, one input bit per clock,
// with start/busy/done handshake and a sticky overflow flag.
module binary_to_bcd_serial #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    binary_to_bcd_serial_if.slave   bus
);
    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = (WIDTH < 2) ? 1 : $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_bin;
    logic [BCD_W-1:0]   r_scratch;
    logic               r_sticky;
    logic [BCD_W-1:0]   r_bcd;
    logic               r_done;
    logic               r_busy;
    logic               r_ovf;

    logic [BCD_W-1:0]   w_adj;
    logic [BCD_W-1:0]   w_shifted;
    logic               w_carry;
    logic               w_last;

    // Add 3 to every scratch digit of 5 or more ahead of this cycle's shift.
    always_comb begin
        w_adj = r_scratch;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (r_scratch[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_scratch[4*i +: 4] + 4'd3;
            end
        end
    end

    // The bit falling off the top digit is the decimal carry beyond 10^DIGITS.
    assign w_carry   = w_adj[BCD_W-1];
    assign w_shifted = {w_adj[BCD_W-2:0], r_bin[WIDTH-1]};
    assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));

    // Control FSM with datapath and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bin     <= '0;
            r_scratch <= '0;
            r_sticky  <= 1'b0;
            r_bcd     <= '0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_busy <= 1'b0;
                    if (bus.start) begin
                        r_bin     <= bus.binary;
                        r_scratch <= '0;
                        r_sticky  <= 1'b0;
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_busy    <= 1'b1;
                    r_scratch <= w_shifted;
                    r_bin     <= r_bin << 1;
                    r_sticky  <= r_sticky | w_carry;
                    r_cnt     <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_bcd   <= r_scratch;
                    r_ovf   <= r_sticky;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.bcd      = r_bcd;
    assign bus.overflow = r_ovf;
endmodule

// File: tb/tb_binary_to_bcd_serial.sv
// Randomized self-checking bench: three converter configurations against a decimal model.
module tb_binary_to_bcd_serial;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    binary_to_bcd_serial_if #(.WIDTH(8),  .DIGITS(3)) a_if ();
    binary_to_bcd_serial_if #(.WIDTH(8),  .DIGITS(2)) b_if ();
    binary_to_bcd_serial_if #(.WIDTH(16), .DIGITS(5)) c_if ();

    binary_to_bcd_serial #(.WIDTH(8),  .DIGITS(3)) u_a (.clk(clk), .rst_n(rst_n), .bus(a_if));
    binary_to_bcd_serial #(.WIDTH(8),  .DIGITS(2)) u_b (.clk(clk), .rst_n(rst_n), .bus(b_if));
    binary_to_bcd_serial #(.WIDTH(16), .DIGITS(5)) u_c (.clk(clk), .rst_n(rst_n), .bus(c_if));

    logic        st    [3];
    logic [31:0] bin_v [3];
    logic        o_done[3];
    logic        o_busy[3];
    logic        o_ovf [3];
    logic [63:0] o_bcd [3];
    int          cfg_w [3];
    int          cfg_d [3];

    assign a_if.start  = st[0];
    assign b_if.start  = st[1];
    assign c_if.start  = st[2];
    assign a_if.binary = bin_v[0][7:0];
    assign b_if.binary = bin_v[1][7:0];
    assign c_if.binary = bin_v[2][15:0];

    assign o_done[0] = a_if.done;     assign o_busy[0] = a_if.busy;
    assign o_done[1] = b_if.done;     assign o_busy[1] = b_if.busy;
    assign o_done[2] = c_if.done;     assign o_busy[2] = c_if.busy;
    assign o_ovf[0]  = a_if.overflow; assign o_bcd[0]  = 64'(a_if.bcd);
    assign o_ovf[1]  = b_if.overflow; assign o_bcd[1]  = 64'(b_if.bcd);
    assign o_ovf[2]  = c_if.overflow; assign o_bcd[2]  = 64'(c_if.bcd);

    int n_tests = 0;
    int n_fail  = 0;
    int cycles  = 0;
    int done_cnt[3] = '{0, 0, 0};

    // Free-running cycle counter and per-DUT done pulse counters.
    always @(posedge clk) begin
        cycles <= cycles + 1;
        for (int i = 0; i < 3; i++) begin
            if (o_done[i]) done_cnt[i] <= done_cnt[i] + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic longint pow10(input int d);
        longint p = 1;
        for (int i = 0; i < d; i++) p = p * 10;
        return p;
    endfunction

    // Decimal model: value mod 10^d written as packed BCD digits.
    function automatic logic [63:0] ref_bcd(input longint v, input int d);
        logic [63:0] r = '0;
        longint m = v % pow10(d);
        for (int i = 0; i < d; i++) begin
            r[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    function automatic logic ref_ovf(input longint v, input int d);
        return v >= pow10(d);
    endfunction

    // Wait, bounded, for done on DUT sel; returns number of ticks waited and busy-high samples.
    task automatic wait_done(input int sel, output int n, output int busy_n);
        n = 0;
        busy_n = 0;
        while (!o_done[sel] && n < 100) begin
            if (o_busy[sel]) busy_n++;
            tick();
            n++;
        end
        if (n >= 100) check("done_timeout", 64'd0, 64'd1);
    endtask

    // One full conversion; binary is scrambled right after acceptance.
    task automatic run(input int sel, input longint v, input bit chk_timing);
        int n, busy_n;
        bin_v[sel] = 32'(v);
        st[sel] = 1'b1;
        tick();
        st[sel] = 1'b0;
        bin_v[sel] = $urandom;
        wait_done(sel, n, busy_n);
        check("bcd", o_bcd[sel], ref_bcd(v, cfg_d[sel]));
        check("ovf", 64'(o_ovf[sel]), 64'(ref_ovf(v, cfg_d[sel])));
        if (chk_timing) begin
            check("latency", 64'(n), 64'(cfg_w[sel] + 1));
            check("busy_cycles", 64'(busy_n), 64'(cfg_w[sel] + 1));
            check("busy_at_done", 64'(o_busy[sel]), 64'd0);
            tick();
            check("done_width", 64'(o_done[sel]), 64'd0);
        end
    endtask

    initial begin
        int perm[256];
        int n, busy_n, d0, acc_prev, tmp, j;
        int b2b[3] = '{43, 21, 30};
        cfg_w = '{8, 8, 16};
        cfg_d = '{3, 2, 5};
        for (int i = 0; i < 3; i++) begin
            st[i] = 1'b0;
            bin_v[i] = '0;
        end

        // Reset state.
        tick();
        tick();
        check("rst_bcd",  o_bcd[0], 64'd0);
        check("rst_busy", 64'(o_busy[0]), 64'd0);
        check("rst_done", 64'(o_done[0]), 64'd0);
        check("rst_ovf",  64'(o_ovf[0]), 64'd0);
        rst_n = 1'b1;
        tick();

        // Directed values with timing.
        run(0, 43, 1'b1);
        run(0, 0, 1'b1);
        run(0, 255, 1'b1);

        // Exhaustive sweep in random order.
        for (int i = 0; i < 256; i++) perm[i] = i;
        for (int i = 255; i > 0; i--) begin
            j = int'($urandom_range(32'(i), 0));
            tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
        end
        for (int i = 0; i < 256; i++) run(0, longint'(perm[i]), 1'b0);

        // Back-to-back with start reasserted in each done cycle.
        tick();
        d0 = done_cnt[0];
        bin_v[0] = 32'(b2b[0]);
        st[0] = 1'b1;
        tick();
        st[0] = 1'b0;
        acc_prev = cycles;
        for (int k = 0; k < 3; k++) begin
            wait_done(0, n, busy_n);
            check("b2b_bcd", o_bcd[0], ref_bcd(longint'(b2b[k]), 3));
            if (k < 2) begin
                bin_v[0] = 32'(b2b[k+1]);
                st[0] = 1'b1;
                tick();
                st[0] = 1'b0;
                check("b2b_spacing", 64'(cycles - acc_prev), 64'd10);
                acc_prev = cycles;
            end
        end
        tick();
        check("b2b_dones", 64'(done_cnt[0] - d0), 64'd3);

        // Start while busy is ignored.
        tick();
        d0 = done_cnt[0];
        bin_v[0] = 32'd43;
        st[0] = 1'b1;
        tick();
        st[0] = 1'b0;
        tick();
        tick();
        bin_v[0] = 32'd99; st[0] = 1'b1; tick(); st[0] = 1'b0;
        tick();
        bin_v[0] = 32'd99; st[0] = 1'b1; tick(); st[0] = 1'b0;
        wait_done(0, n, busy_n);
        check("ign_bcd", o_bcd[0], 64'h043);
        for (int i = 0; i < 15; i++) tick();
        check("ign_dones", 64'(done_cnt[0] - d0), 64'd1);
        check("ign_busy", 64'(o_busy[0]), 64'd0);

        // Reset mid-conversion aborts it.
        d0 = done_cnt[0];
        bin_v[0] = 32'd200;
        st[0] = 1'b1;
        tick();
        st[0] = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        check("abort_bcd",  o_bcd[0], 64'd0);
        check("abort_busy", 64'(o_busy[0]), 64'd0);
        check("abort_done", 64'(o_done[0]), 64'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        check("abort_nodone", 64'(done_cnt[0] - d0), 64'd0);
        run(0, 7, 1'b1);

        // Two-digit overflow configuration.
        run(1, 200, 1'b1);
        run(1, 99, 1'b1);
        run(1, 100, 1'b0);
        for (int i = 0; i < 20; i++) run(1, longint'($urandom_range(255, 0)), 1'b0);

        // Sixteen-bit, five-digit configuration.
        run(2, 65535, 1'b1);
        run(2, 0, 1'b0);
        for (int i = 0; i < 20; i++) run(2, longint'($urandom_range(65535, 0)), 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
